// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch stage
package fetch_pkg;
  localparam int unsigned PC_W = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 64'h0;
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small register FIFO buffering fetched {pc, instr} entries
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  // storage, pointers and occupancy; flush empties without touching storage
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= data_i;
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem address driver and instruction buffer for decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 2,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF)
) (
  input  logic                       i_clk,
  input  logic                       i_arst,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [INSTR_WIDTH-1:0]     i_imem_data,
  input  logic                       i_redirect_valid,
  input  logic [PC_WIDTH-1:0]        i_redirect_pc,
  output logic                       o_instr_valid,
  input  logic                       i_instr_ready,
  output logic [INSTR_WIDTH-1:0]     o_instr,
  output logic [PC_WIDTH-1:0]        o_instr_pc,
  output logic                       o_fault
);
  localparam int EW = PC_WIDTH + INSTR_WIDTH;
  fetch_state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic push, pop, full, empty, fault;
  logic [EW-1:0] head;
  // state and pc registers
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  // next state: any redirect reloads the pc, alignment picks RUN or FAULT
  always_comb begin
    state_d = i_redirect_valid ? (i_redirect_pc[1:0] == 2'b00 ? RUN : FAULT) : state_q;
    pc_d    = i_redirect_valid ? i_redirect_pc : push ? pc_q + PC_WIDTH'(4) : pc_q;
  end
  // outputs: fetch only while running and not redirecting, keep one slot per pop
  always_comb begin
    fault = state_q == FAULT;
    pop   = !empty && i_instr_ready;
    push  = !i_redirect_valid && !fault && (!full || pop);
  end
  fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (i_clk),
    .arst_i (i_arst),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(i_redirect_valid),
    .data_i ({pc_q, i_imem_data}),
    .full_o (full),
    .empty_o(empty),
    .head_o (head)
  );
  assign o_imem_addr   = pc_q[IMEM_ADDR_WIDTH-1:0];
  assign o_instr_valid = !empty;
  assign o_instr       = head[INSTR_WIDTH-1:0];
  assign o_instr_pc    = head[EW-1:INSTR_WIDTH];
  assign o_fault       = fault;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a queue model
module tb_fetch_unit;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;
  logic        i_clk, i_arst;
  logic [9:0]  o_imem_addr;
  logic [31:0] i_imem_data;
  logic        i_redirect_valid;
  logic [63:0] i_redirect_pc;
  logic        o_instr_valid, i_instr_ready;
  logic [31:0] o_instr;
  logic [63:0] o_instr_pc;
  logic        o_fault;
  int checks = 0;
  int errors = 0;
  ent_t        q[$];
  logic [63:0] mpc;
  bit          mfault;

  fetch_unit dut (
    .i_clk(i_clk), .i_arst(i_arst), .o_imem_addr(o_imem_addr), .i_imem_data(i_imem_data),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready), .o_instr(o_instr),
    .o_instr_pc(o_instr_pc), .o_fault(o_fault)
  );

  function automatic logic [31:0] mw(input logic [63:0] a);
    return 32'h1000_0000 + {24'h0, a[9:2]};
  endfunction

  assign i_imem_data = mw({54'h0, o_imem_addr});

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc = 64'h0;
    mfault = 1'b0;
  endtask

  // check current outputs against the model, apply inputs, advance one clock
  task automatic step(input logic rdy, input logic rv, input logic [63:0] rpc);
    bit ev, pop, push;
    ent_t e;
    i_instr_ready = rdy;
    i_redirect_valid = rv;
    i_redirect_pc = rpc;
    ev = q.size() != 0;
    chk("valid", {63'h0, o_instr_valid}, {63'h0, ev});
    chk("fault", {63'h0, o_fault}, {63'h0, mfault});
    chk("imem_addr", {54'h0, o_imem_addr}, {54'h0, mpc[9:0]});
    if (ev) begin
      chk("instr", {32'h0, o_instr}, {32'h0, q[0].instr});
      chk("instr_pc", o_instr_pc, q[0].pc);
    end
    pop = ev && rdy;
    if (rv) begin
      q.delete();
      mpc = rpc;
      mfault = rpc[1:0] != 2'b00;
    end else if (!mfault) begin
      push = q.size() < DEPTH || pop;
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc = mpc;
        e.instr = mw(mpc);
        q.push_back(e);
        mpc = mpc + 64'd4;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [63:0] t;
    int r;
    i_arst = 1'b1;
    i_instr_ready = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc = 64'h0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", {63'h0, o_instr_valid}, 64'h0);
    chk("rst_instr", {32'h0, o_instr}, 64'h0);
    chk("rst_instr_pc", o_instr_pc, 64'h0);
    chk("rst_fault", {63'h0, o_fault}, 64'h0);
    chk("rst_addr", {54'h0, o_imem_addr}, 64'h0);
    i_arst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 64'h0);
      chk("seq_pc", o_instr_pc, 64'(k * 4));
      chk("seq_instr", {32'h0, o_instr}, 64'(32'h1000_0000 + k));
    end
    step(1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0);
    i_arst = 1'b1;
    #1;
    chk("arst_valid", {63'h0, o_instr_valid}, 64'h0);
    chk("arst_addr", {54'h0, o_imem_addr}, 64'h0);
    chk("arst_instr_pc", o_instr_pc, 64'h0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_arst = 1'b0;
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 64'h0);
    chk("hold_addr", {54'h0, o_imem_addr}, 64'h8);
    chk("hold_valid", {63'h0, o_instr_valid}, 64'h1);
    for (int k = 0; k < 3; k++) begin
      chk("resume_pc", o_instr_pc, 64'(k * 4));
      step(1'b1, 1'b0, 64'h0);
    end
    step(1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b1, 64'h40);
    chk("redir_valid", {63'h0, o_instr_valid}, 64'h0);
    step(1'b1, 1'b0, 64'h0);
    chk("redir_pc0", o_instr_pc, 64'h40);
    step(1'b1, 1'b0, 64'h0);
    chk("redir_pc1", o_instr_pc, 64'h44);
    step(1'b1, 1'b1, 64'h42);
    for (int k = 0; k < 10; k++) begin
      chk("fault_hi", {63'h0, o_fault}, 64'h1);
      chk("fault_valid", {63'h0, o_instr_valid}, 64'h0);
      step(1'b1, 1'b0, 64'h0);
    end
    step(1'b1, 1'b1, 64'h80);
    chk("fault_clr", {63'h0, o_fault}, 64'h0);
    step(1'b1, 1'b0, 64'h0);
    chk("fault_exit_pc", o_instr_pc, 64'h80);
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b0, 64'h0);
    chk("wrap_addr", {54'h0, o_imem_addr}, 64'h0);
    chk("wrap_head", o_instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      t = {$urandom, $urandom} & ~64'h3;
      if (r < 2) t = t | 64'(r + 1);
      else if (r < 4) t = 64'hFFFF_FFFF_FFFF_FFF8;
      step($urandom_range(0, 3) != 0, r < 10, t);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
